// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word read per instruction and presents the
// result to decode under a valid/ready handshake. Optional macro: FETCH_REDIRECT_EN.
`timescale 1ns/1ps
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              resetn,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [4:0]        opcode,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef FETCH_REDIRECT_EN
  ,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [31:0]       instr_q;
  logic              valid_q;

  logic              handshake;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_tgt;

  // NOTE: handshake/redirect are continuous assigns, so every bit is always
  // driven and no latch can be inferred for them.
  assign handshake = (state_q == HOLD) && valid_q && instr_ready;

`ifdef FETCH_REDIRECT_EN
  assign redirect     = redirect_valid && (state_q != IDLE);
  assign redirect_tgt = redirect_pc;
`else
  assign redirect     = 1'b0;
  assign redirect_tgt = pc_q;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else if (redirect) begin
      // Going back to ISSUE (not CAPTURE) drops whatever read is in flight.
      state_q <= ISSUE;
      pc_q    <= redirect_tgt;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    state_q <= ISSUE;
        ISSUE:   state_q <= CAPTURE;
        CAPTURE: begin
          instr_q  <= imem_rdata;
          pc_out_q <= pc_q;
          valid_q  <= 1'b1;
          pc_q     <= pc_q + 1'b1;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (handshake) begin
            valid_q <= 1'b0;
            state_q <= CAPTURE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The read for the next word is launched in the handshake cycle itself,
  // which keeps throughput at one instruction every two cycles.
  assign imem_en     = (state_q == ISSUE) || handshake;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:27];
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances (RESET_PC 0 and 12'hFFF) share
// stimulus; each has its own one-cycle-latency memory model.
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          resetn;
  logic          instr_ready;
  logic [31:0]   mem [0:4095];

  logic          en_a, en_b, valid_a, valid_b;
  logic [AW-1:0] addr_a, addr_b, pcout_a, pcout_b;
  logic [31:0]   rdata_a, rdata_b, instr_a, instr_b;
  logic [4:0]    opc_a, opc_b;
`ifdef FETCH_REDIRECT_EN
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  instr_fetch #(.ADDR_W(AW), .RESET_PC(12'h000)) dut_a (
    .clock(clock), .resetn(resetn), .imem_en(en_a), .imem_addr(addr_a),
    .imem_rdata(rdata_a), .instr(instr_a), .opcode(opc_a), .pc_out(pcout_a),
    .instr_valid(valid_a), .instr_ready(instr_ready)
`ifdef FETCH_REDIRECT_EN
    , .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`endif
  );

  instr_fetch #(.ADDR_W(AW), .RESET_PC(12'hFFF)) dut_b (
    .clock(clock), .resetn(resetn), .imem_en(en_b), .imem_addr(addr_b),
    .imem_rdata(rdata_b), .instr(instr_b), .opcode(opc_b), .pc_out(pcout_b),
    .instr_valid(valid_b), .instr_ready(instr_ready)
`ifdef FETCH_REDIRECT_EN
    , .redirect_valid(1'b0), .redirect_pc(12'h000)
`endif
  );

  always_ff @(posedge clock) begin
    if (en_a) rdata_a <= mem[addr_a];
    if (en_b) rdata_b <= mem[addr_b];
  end

  task automatic hold_reset();
    resetn      = 1'b0;
`ifdef FETCH_REDIRECT_EN
    redirect_valid = 1'b0;
    redirect_pc    = '0;
`endif
    repeat (2) @(negedge clock);
  endtask

  task automatic release_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    instr_ready = 1'b1;
    resetn = 1'b0;
    #1;
    checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", en_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
    checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr_a); end
    checks++; if (opc_a !== 5'h0) begin errors++; $display("FAIL reset_opcode got %h want 0", opc_a); end
    checks++; if (pcout_a !== 12'h000) begin errors++; $display("FAIL reset_pc_out got %h want 000", pcout_a); end
    checks++; if (addr_a !== 12'h000) begin errors++; $display("FAIL reset_addr got %h want 000", addr_a); end
    checks++; if (pcout_b !== 12'hFFF) begin errors++; $display("FAIL reset_pc_out_b got %h want fff", pcout_b); end
    checks++; if (addr_b !== 12'hFFF) begin errors++; $display("FAIL reset_addr_b got %h want fff", addr_b); end
    @(negedge clock);
    checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL reset_held_en got %b want 0", en_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_held_valid got %b want 0", valid_a); end
  endtask

  task automatic test_first_fetch();
    instr_ready = 1'b1;
    hold_reset();
    release_reset();
    #1;
    checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL first_idle_en got %b want 0", en_a); end
    @(negedge clock);
    checks++; if (en_a !== 1'b1) begin errors++; $display("FAIL first_issue_en got %b want 1", en_a); end
    checks++; if (addr_a !== 12'h000) begin errors++; $display("FAIL first_issue_addr got %h want 000", addr_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL first_issue_valid got %b want 0", valid_a); end
    @(negedge clock);
    checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL first_capture_en got %b want 0", en_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL first_capture_valid got %b want 0", valid_a); end
    @(negedge clock);
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", valid_a); end
    checks++; if (opc_a !== 5'b00101) begin errors++; $display("FAIL first_opcode got %b want 00101", opc_a); end
    checks++; if (pcout_a !== 12'h000) begin errors++; $display("FAIL first_pc_out got %h want 000", pcout_a); end
    checks++; if (instr_a !== 32'h2800_0000) begin errors++; $display("FAIL first_instr got %h want 28000000", instr_a); end
  endtask

  task automatic test_stream();
    logic [31:0] word;
    instr_ready = 1'b1;
    hold_reset();
    release_reset();
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      word = mem[i];
      checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, valid_a); end
      checks++; if (pcout_a !== AW'(i)) begin errors++; $display("FAIL stream_pc_out[%0d] got %h want %h", i, pcout_a, AW'(i)); end
      checks++; if (opc_a !== word[31:27]) begin errors++; $display("FAIL stream_opcode[%0d] got %h want %h", i, opc_a, word[31:27]); end
      checks++; if (instr_a !== word) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, instr_a, word); end
      checks++; if (en_a !== 1'b1 || addr_a !== AW'(i + 1)) begin errors++; $display("FAIL stream_issue[%0d] got en=%b addr=%h want en=1 addr=%h", i, en_a, addr_a, AW'(i + 1)); end
      @(negedge clock);
      checks++; if (valid_a !== 1'b0 || en_a !== 1'b0) begin errors++; $display("FAIL stream_gap[%0d] got valid=%b en=%b want 0 0", i, valid_a, en_a); end
      @(negedge clock);
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    hold_reset();
    release_reset();
    repeat (3) @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      checks++; if (valid_a !== 1'b1 || instr_a !== mem[0] || pcout_a !== 12'h000) begin errors++; $display("FAIL stall_hold[%0d] got valid=%b instr=%h pc_out=%h want 1 %h 000", k, valid_a, instr_a, pcout_a, mem[0]); end
      checks++; if (en_a !== 1'b0 || addr_a !== 12'h001 || opc_a !== 5'b00101) begin errors++; $display("FAIL stall_mem[%0d] got en=%b addr=%h opc=%b want 0 001 00101", k, en_a, addr_a, opc_a); end
      @(negedge clock);
    end
    instr_ready = 1'b1;
    #1;
    checks++; if (en_a !== 1'b1 || addr_a !== 12'h001) begin errors++; $display("FAIL stall_release got en=%b addr=%h want 1 001", en_a, addr_a); end
    @(negedge clock);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL stall_capture_valid got %b want 0", valid_a); end
    @(negedge clock);
    checks++; if (pcout_a !== 12'h001 || instr_a !== mem[1]) begin errors++; $display("FAIL stall_next got pc_out=%h instr=%h want 001 %h", pcout_a, instr_a, mem[1]); end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1;
    hold_reset();
    release_reset();
    repeat (3) @(negedge clock);
    checks++; if (pcout_b !== 12'hFFF || instr_b !== mem[4095]) begin errors++; $display("FAIL wrap_first got pc_out=%h instr=%h want fff %h", pcout_b, instr_b, mem[4095]); end
    checks++; if (en_b !== 1'b1 || addr_b !== 12'h000) begin errors++; $display("FAIL wrap_addr got en=%b addr=%h want 1 000", en_b, addr_b); end
    repeat (2) @(negedge clock);
    checks++; if (valid_b !== 1'b1 || pcout_b !== 12'h000 || instr_b !== mem[0]) begin errors++; $display("FAIL wrap_second got valid=%b pc_out=%h instr=%h want 1 000 %h", valid_b, pcout_b, instr_b, mem[0]); end
  endtask

  task automatic test_reset_mid_capture();
    instr_ready = 1'b1;
    hold_reset();
    release_reset();
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++; if (valid_a !== 1'b0 || instr_a !== 32'h0 || opc_a !== 5'h0) begin errors++; $display("FAIL midrst_data got valid=%b instr=%h opc=%h want 0 0 0", valid_a, instr_a, opc_a); end
    checks++; if (en_a !== 1'b0 || addr_a !== 12'h000 || pcout_a !== 12'h000) begin errors++; $display("FAIL midrst_ctrl got en=%b addr=%h pc_out=%h want 0 000 000", en_a, addr_a, pcout_a); end
    @(negedge clock);
    checks++; if (instr_a !== 32'h0) begin errors++; $display("FAIL midrst_held got %h want 0", instr_a); end
    resetn = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clock);
      checks++; if (instr_a !== 32'h0 || valid_a !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d] got instr=%h valid=%b want 0 0", e, instr_a, valid_a); end
    end
    @(negedge clock);
    checks++; if (instr_a !== mem[0] || pcout_a !== 12'h000 || valid_a !== 1'b1) begin errors++; $display("FAIL midrst_refetch got instr=%h pc_out=%h valid=%b want %h 000 1", instr_a, pcout_a, valid_a, mem[0]); end
  endtask

`ifdef FETCH_REDIRECT_EN
  task automatic test_redirect();
    instr_ready = 1'b0;
    hold_reset();
    release_reset();
    repeat (2) @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc    = 12'h040;
    @(negedge clock);
    redirect_valid = 1'b0;
    checks++; if (valid_a !== 1'b0 || en_a !== 1'b1 || addr_a !== 12'h040) begin errors++; $display("FAIL redir_issue got valid=%b en=%b addr=%h want 0 1 040", valid_a, en_a, addr_a); end
    repeat (2) @(negedge clock);
    checks++; if (valid_a !== 1'b1 || pcout_a !== 12'h040 || instr_a !== mem[64]) begin errors++; $display("FAIL redir_word got valid=%b pc_out=%h instr=%h want 1 040 %h", valid_a, pcout_a, instr_a, mem[64]); end
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 12'h080;
    @(negedge clock);
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    checks++; if (valid_a !== 1'b0 || en_a !== 1'b1 || addr_a !== 12'h080) begin errors++; $display("FAIL redir_prio got valid=%b en=%b addr=%h want 0 1 080", valid_a, en_a, addr_a); end
    repeat (2) @(negedge clock);
    checks++; if (valid_a !== 1'b1 || pcout_a !== 12'h080 || instr_a !== mem[128]) begin errors++; $display("FAIL redir_prio_word got valid=%b pc_out=%h instr=%h want 1 080 %h", valid_a, pcout_a, instr_a, mem[128]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {5'(i * 7 + 3), 27'(i * 32'h0001_9E37 + 5)};
    mem[0] = 32'h2800_0000;
    resetn      = 1'b1;
    instr_ready = 1'b0;
`ifdef FETCH_REDIRECT_EN
    redirect_valid = 1'b0;
    redirect_pc    = '0;
`endif
    #2;
    test_reset();
    test_first_fetch();
    test_stream();
    test_stall();
    test_wrap();
    test_reset_mid_capture();
`ifdef FETCH_REDIRECT_EN
    test_redirect();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
